inst_fetch_queue: RTL and testbench

Circular FIFO between the instruction fetch/decode stage and issue. Accepts one decoded instruction per cycle from fetch, holds up to DEPTH entries with their PC and prediction bit, and presents the oldest entry to issue under a valid/ready handshake. Drives `foq_full` back to fetch, which stalls its PC. Flushes completely on branch mispredict.

---
 rtl/inst_fetch_queue.sv | 116 +++++++++++
 tb/tb_inst_fetch_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Circular instruction queue between fetch/decode and issue.
// Oldest entry is presented combinationally on deq_*; handshake is valid/ready.
module inst_fetch_queue #(
  parameter int DEPTH = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic                       enq_valid,
  input  logic [31:0]                enq_pc,
  input  logic                       enq_pred,
  input  logic [4:0]                 enq_op,
  input  logic                       enq_branch,
  input  logic                       enq_ls,
  input  logic                       enq_use_imm,
  input  logic                       enq_jalr,
  input  logic [4:0]                 enq_rd,
  input  logic [4:0]                 enq_rs1,
  input  logic [4:0]                 enq_rs2,
  input  logic [31:0]                enq_imm,
  output logic                       foq_full,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [31:0]                deq_pc,
  output logic                       deq_pred,
  output logic [4:0]                 deq_op,
  output logic                       deq_branch,
  output logic                       deq_ls,
  output logic                       deq_use_imm,
  output logic                       deq_jalr,
  output logic [4:0]                 deq_rd,
  output logic [4:0]                 deq_rs1,
  output logic [4:0]                 deq_rs2,
  output logic [31:0]                deq_imm,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic [4:0]  op;
    logic        branch;
    logic        ls;
    logic        use_imm;
    logic        jalr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        enq_entry;
  entry_t        head_entry;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count_q;
  logic          enq_fire;
  logic          deq_fire;

  // Status depends on registered occupancy only, so full/valid never see same-cycle traffic.
  assign foq_full  = (count_q == FULL_CNT);
  assign deq_valid = (count_q != '0);
  assign count     = count_q;

  assign enq_fire = rdy_in && enq_valid && !foq_full && !flush_in;
  assign deq_fire = rdy_in && deq_valid && deq_ready && !flush_in;

  assign enq_entry = '{pc: enq_pc, pred: enq_pred, op: enq_op, branch: enq_branch,
                       ls: enq_ls, use_imm: enq_use_imm, jalr: enq_jalr,
                       rd: enq_rd, rs1: enq_rs1, rs2: enq_rs2, imm: enq_imm};

  assign head_entry  = mem[head];
  assign deq_pc      = head_entry.pc;
  assign deq_pred    = head_entry.pred;
  assign deq_op      = head_entry.op;
  assign deq_branch  = head_entry.branch;
  assign deq_ls      = head_entry.ls;
  assign deq_use_imm = head_entry.use_imm;
  assign deq_jalr    = head_entry.jalr;
  assign deq_rd      = head_entry.rd;
  assign deq_rs1     = head_entry.rs1;
  assign deq_rs2     = head_entry.rs2;
  assign deq_imm     = head_entry.imm;

  // NOTE: storage has no reset; occupancy is tracked by count_q, so stale contents are never consumed.
  always_ff @(posedge clk_in) begin
    if (enq_fire) mem[tail] <= enq_entry;
  end

  // NOTE: non-blocking assignments keep every register update on the same edge, order-independent.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush_in) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) tail <= tail + 1'b1;
      if (deq_fire) head <= head + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: stimulus pushes expected PCs, a negedge monitor pops on each dequeue.
module tb_inst_fetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic [4:0]  op;
    logic        branch;
    logic        ls;
    logic        use_imm;
    logic        jalr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } ent_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        enq_valid = 1'b0;
  logic [31:0] enq_pc = '0;
  logic        enq_pred = 1'b0;
  logic [4:0]  enq_op = '0;
  logic        enq_branch = 1'b0, enq_ls = 1'b0, enq_use_imm = 1'b0, enq_jalr = 1'b0;
  logic [4:0]  enq_rd = '0, enq_rs1 = '0, enq_rs2 = '0;
  logic [31:0] enq_imm = '0;
  logic        foq_full;
  logic        deq_ready = 1'b0;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic        deq_pred;
  logic [4:0]  deq_op;
  logic        deq_branch, deq_ls, deq_use_imm, deq_jalr;
  logic [4:0]  deq_rd, deq_rs1, deq_rs2;
  logic [31:0] deq_imm;
  logic [4:0]  count;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] sb[$];

  inst_fetch_queue #(.DEPTH(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred(enq_pred), .enq_op(enq_op),
    .enq_branch(enq_branch), .enq_ls(enq_ls), .enq_use_imm(enq_use_imm), .enq_jalr(enq_jalr),
    .enq_rd(enq_rd), .enq_rs1(enq_rs1), .enq_rs2(enq_rs2), .enq_imm(enq_imm),
    .foq_full(foq_full), .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_pc(deq_pc), .deq_pred(deq_pred), .deq_op(deq_op), .deq_branch(deq_branch),
    .deq_ls(deq_ls), .deq_use_imm(deq_use_imm), .deq_jalr(deq_jalr),
    .deq_rd(deq_rd), .deq_rs1(deq_rs1), .deq_rs2(deq_rs2), .deq_imm(deq_imm),
    .count(count)
  );

  always #5 clk_in = ~clk_in;

  // Decoded fields are a fixed function of the PC, so one PC identifies a whole entry.
  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e = '0;
    e.pc = pc;
    e.pred = pc[2];
    e.op = pc[6:2];
    e.branch = pc[3];
    e.ls = pc[4];
    e.use_imm = pc[5];
    e.jalr = pc[6] ^ pc[2];
    e.rd = pc[8:4];
    e.rs1 = pc[7:3];
    e.rs2 = ~pc[6:2];
    e.imm = pc * 3 + 1;
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic present(input logic [31:0] pc);
    ent_t e;
    e = mk(pc);
    enq_valid = 1'b1;
    enq_pc = e.pc; enq_pred = e.pred; enq_op = e.op;
    enq_branch = e.branch; enq_ls = e.ls; enq_use_imm = e.use_imm; enq_jalr = e.jalr;
    enq_rd = e.rd; enq_rs1 = e.rs1; enq_rs2 = e.rs2; enq_imm = e.imm;
  endtask

  // Present pc and record it as expected to be accepted on the next edge.
  task automatic enq_accept(input logic [31:0] pc);
    present(pc);
    sb.push_back(pc);
  endtask

  // Monitor: whenever a dequeue will fire at the next edge, the head must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_in && rdy_in && !flush_in && deq_valid && deq_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow_pc", deq_pc, 32'hdead_beef);
        end else begin
          logic [31:0] exp_pc;
          ent_t act;
          exp_pc = sb.pop_front();
          act = '{pc: deq_pc, pred: deq_pred, op: deq_op, branch: deq_branch, ls: deq_ls,
                  use_imm: deq_use_imm, jalr: deq_jalr, rd: deq_rd, rs1: deq_rs1,
                  rs2: deq_rs2, imm: deq_imm};
          check("deq_entry", act, mk(exp_pc));
        end
      end
    end
  end

  initial begin
    // Reset state
    #3;
    check("rst_count", count, 0);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_full", foq_full, 0);
    #9 rst_in = 1'b1;

    // In-order enqueue then drain
    enq_accept(32'h0);
    tick();
    check("t1_valid_after_first", deq_valid, 1);
    check("t1_head_pc", deq_pc, 32'h0);
    enq_accept(32'h4);
    tick();
    enq_accept(32'h8);
    tick();
    enq_valid = 1'b0;
    check("t1_count3", count, 3);
    check("t1_head_still_0", deq_pc, 32'h0);
    deq_ready = 1'b1;
    repeat (3) tick();
    deq_ready = 1'b0;
    check("t1_count0", count, 0);
    check("t1_valid0", deq_valid, 0);

    // Fill to full, refuse 17th, simultaneous full enq+deq
    for (int i = 0; i < 16; i++) begin
      enq_accept(32'(i * 4));
      tick();
    end
    check("t2_full", foq_full, 1);
    check("t2_count16", count, 16);
    present(32'h40);
    tick();
    check("t2_drop_count", count, 16);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    check("t2_count15", count, 15);
    check("t2_not_full", foq_full, 0);
    sb.push_back(32'h40);
    tick();
    enq_valid = 1'b0;
    check("t2_refull", count, 16);
    deq_ready = 1'b1;
    repeat (16) tick();
    deq_ready = 1'b0;
    check("t2_drained", count, 0);

    // Sustained throughput at count=5 across pointer wrap
    for (int i = 0; i < 5; i++) begin
      enq_accept(32'h200 + 32'(i * 4));
      tick();
    end
    deq_ready = 1'b1;
    for (int i = 5; i < 45; i++) begin
      enq_accept(32'h200 + 32'(i * 4));
      tick();
      if (i % 10 == 0) check("t3_count_hold", count, 5);
    end
    enq_valid = 1'b0;
    check("t3_count5", count, 5);
    repeat (5) tick();
    deq_ready = 1'b0;
    check("t3_drained", count, 0);

    // Flush overrides simultaneous enq/deq
    for (int i = 0; i < 7; i++) begin
      enq_accept(32'h400 + 32'(i * 4));
      tick();
    end
    check("t4_count7", count, 7);
    present(32'h4f0);
    deq_ready = 1'b1;
    flush_in = 1'b1;
    tick();
    sb.delete();
    flush_in = 1'b0;
    deq_ready = 1'b0;
    enq_valid = 1'b0;
    check("t4_flush_count", count, 0);
    check("t4_flush_valid", deq_valid, 0);
    enq_accept(32'h500);
    tick();
    enq_valid = 1'b0;
    check("t4_post_flush_count", count, 1);
    check("t4_post_flush_pc", deq_pc, 32'h500);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    check("t4_empty", count, 0);

    // rdy_in low freezes; flush still acts
    for (int i = 0; i < 3; i++) begin
      enq_accept(32'h600 + 32'(i * 4));
      tick();
    end
    rdy_in = 1'b0;
    present(32'h700);
    deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_frozen_count", count, 3);
    end
    enq_valid = 1'b0;
    rdy_in = 1'b1;
    repeat (3) tick();
    deq_ready = 1'b0;
    check("t5_drained", count, 0);
    enq_accept(32'h680);
    tick();
    enq_accept(32'h684);
    tick();
    enq_valid = 1'b0;
    rdy_in = 1'b0;
    flush_in = 1'b1;
    tick();
    sb.delete();
    flush_in = 1'b0;
    rdy_in = 1'b1;
    check("t5_flush_norcy_count", count, 0);
    check("t5_flush_norcy_valid", deq_valid, 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 9; i++) begin
      enq_accept(32'h800 + 32'(i * 4));
      tick();
    end
    enq_valid = 1'b0;
    check("t6_count9", count, 9);
    #2 rst_in = 1'b0;
    #1;
    check("t6_async_count", count, 0);
    check("t6_async_valid", deq_valid, 0);
    check("t6_async_full", foq_full, 0);
    sb.delete();
    #2 rst_in = 1'b1;
    tick();
    enq_accept(32'h100);
    tick();
    enq_valid = 1'b0;
    check("t6_valid", deq_valid, 1);
    check("t6_pc", deq_pc, 32'h100);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    check("t6_empty", count, 0);
    check("sb_empty_at_end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
